// File: rtl/braille_cell_driver.sv
// Queues classified characters and plays each as a 6-dot braille pattern: HOLD_CYC cycles raised, GAP_CYC cycles down.
// First pattern appears one edge after the strobe into an empty idle FIFO; no backpressure, a full FIFO drops and flags.
module braille_cell_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_CYC   = 100000,
    parameter int GAP_CYC    = 20000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_valid,
    input  logic [7:0]                    i_alpha,
    output logic [5:0]                    o_dots,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overflow,
    output logic                          o_bad_char,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CTW  = $clog2(MAXC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CTW-1:0] ctr_q, ctr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [5:0]     dots_q, dots_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           overflow_q, overflow_d;
    logic           bad_char_q, bad_char_d;

    logic           pop;
    logic           push;
    logic [7:0]     head;

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        dots_d     = dots_q;
        bad_char_d = 1'b0;
        head       = mem_q[rd_ptr_q];

        // A full FIFO still takes a new char on the edge where IDLE frees a slot.
        pop  = (state_q == S_IDLE) && (cnt_q != '0);
        push = i_valid && ((cnt_q < CW'(FIFO_DEPTH)) || pop);
        overflow_d = i_valid && !push;

        case (state_q)
            S_IDLE: begin
                dots_d = 6'b000000;
                if (pop) begin
                    state_d = S_HOLD;
                    ctr_d   = '0;
                    case (head)
                        8'h61:   dots_d = 6'b000001;
                        8'h62:   dots_d = 6'b000011;
                        8'h63:   dots_d = 6'b001001;
                        default: begin
                            dots_d     = 6'b000000;
                            bad_char_d = 1'b1;
                        end
                    endcase
                end
            end
            S_HOLD: begin
                if (ctr_q == CTW'(HOLD_CYC - 1)) begin
                    state_d = S_GAP;
                    ctr_d   = '0;
                    dots_d  = 6'b000000;
                end else begin
                    ctr_d = ctr_q + CTW'(1);
                end
            end
            S_GAP: begin
                dots_d = 6'b000000;
                if (ctr_q == CTW'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CTW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ctr_d   = '0;
                dots_d  = 6'b000000;
            end
        endcase

        // Registered pulse lands in the cycle the counter sits on the last gap count.
        done_d = (state_d == S_GAP) && (ctr_d == CTW'(GAP_CYC - 1));
        busy_d = (state_d != S_IDLE);

        if (push) begin
            mem_d[wr_ptr_q] = i_alpha;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ctr_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            dots_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bad_char_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            dots_q     <= dots_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bad_char_q <= bad_char_d;
            mem_q      <= mem_d;
        end
    end

    assign o_dots     = dots_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_bad_char = bad_char_q;
    assign o_fifo_cnt = cnt_q;
endmodule

// File: tb/tb_braille_cell_driver.sv
// Randomised and directed bench for braille_cell_driver against a slot-timeline reference model.
module tb_braille_cell_driver;
    localparam int D = 4;
    localparam int H = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_alpha = 8'h00;
    logic [5:0] o_dots;
    logic       o_busy;
    logic       o_done;
    logic       o_overflow;
    logic       o_bad_char;
    logic [2:0] o_fifo_cnt;

    braille_cell_driver #(.FIFO_DEPTH(D), .HOLD_CYC(H), .GAP_CYC(G)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .i_alpha    (i_alpha),
        .o_dots     (o_dots),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overflow (o_overflow),
        .o_bad_char (o_bad_char),
        .o_fifo_cnt (o_fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a character queue plus the start edge of the slot being played.
    logic [7:0] q[$];
    int         t         = 0;
    int         next_free = 0;
    int         start     = 0;
    bit         have_slot = 0;
    logic [5:0] cur_pat   = '0;
    int         done_cnt, ovf_cnt, bad_cnt, max_cnt;

    function automatic logic [5:0] pat_of(input logic [7:0] c);
        case (c)
            8'h61:   return 6'b000001;
            8'h62:   return 6'b000011;
            8'h63:   return 6'b001001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic bit known(input logic [7:0] c);
        return (c == 8'h61) || (c == 8'h62) || (c == 8'h63);
    endfunction

    task automatic clear_counts();
        done_cnt = 0; ovf_cnt = 0; bad_cnt = 0; max_cnt = 0;
    endtask

    task automatic cycle(input logic v, input logic [7:0] a);
        bit         pop, acc, e_ovf, e_bad;
        int         k;
        logic [7:0] c;
        i_valid = v;
        i_alpha = a;
        @(posedge clk);
        pop   = (t >= next_free) && (q.size() > 0);
        acc   = v && ((q.size() < D) || pop);
        e_bad = 1'b0;
        if (pop) begin
            c         = q.pop_front();
            cur_pat   = pat_of(c);
            e_bad     = !known(c);
            have_slot = 1'b1;
            start     = t;
            next_free = t + H + G + 1;
        end
        if (acc) q.push_back(a);
        e_ovf = v && !acc;
        k = t - start;
        #1;
        check("dots",     o_dots,     (have_slot && k < H) ? cur_pat : 6'b0);
        check("busy",     o_busy,     have_slot && k < H + G);
        check("done",     o_done,     have_slot && k == H + G - 1);
        check("overflow", o_overflow, e_ovf);
        check("bad_char", o_bad_char, e_bad);
        check("fifo_cnt", o_fifo_cnt, q.size());
        done_cnt += int'(o_done);
        ovf_cnt  += int'(o_overflow);
        bad_cnt  += int'(o_bad_char);
        if (int'(o_fifo_cnt) > max_cnt) max_cnt = int'(o_fifo_cnt);
        i_valid = 1'b0;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic model_reset();
        q.delete();
        have_slot = 1'b0;
        next_free = 0;
        t         = 0;
    endtask

    initial begin
        int         k;
        int         sel;
        logic [7:0] ch;
        clear_counts();

        repeat (3) @(posedge clk);
        #1;
        check("rst_dots", o_dots, 0);
        check("rst_busy", o_busy, 0);
        check("rst_cnt",  o_fifo_cnt, 0);
        check("rst_flags", {o_done, o_overflow, o_bad_char}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Single 'b'
        clear_counts();
        cycle(1'b1, 8'h62);
        idle(15);
        check("t1_done_cnt", done_cnt, 1);

        // a,b,c back to back
        clear_counts();
        cycle(1'b1, 8'h61);
        cycle(1'b1, 8'h62);
        cycle(1'b1, 8'h63);
        idle(45);
        check("t2_max_cnt", max_cnt, 2);
        check("t2_done_cnt", done_cnt, 3);

        // Overflow while busy, then push on the full-FIFO pop edge
        clear_counts();
        cycle(1'b1, 8'h61);
        cycle(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h61 + 8'($urandom_range(0, 2)));
        check("t3_ovf_cnt", ovf_cnt, 2);
        k = 0;
        while (t < next_free && k < 40) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        check("t4_idle_before_pop", o_busy, 0);
        check("t4_cnt_full", o_fifo_cnt, 4);
        cycle(1'b1, 8'h63);
        check("t4_no_ovf", o_overflow, 0);
        check("t4_cnt_stays", o_fifo_cnt, 4);
        idle(80);
        check("t3_done_cnt", done_cnt, 6);
        check("t3_ovf_total", ovf_cnt, 2);

        // Unknown character still plays a silent slot
        clear_counts();
        cycle(1'b1, 8'h7A);
        idle(20);
        check("t5_bad_cnt", bad_cnt, 1);
        check("t5_done_cnt", done_cnt, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0, 1, 2: ch = 8'h61 + 8'(sel);
                3:       ch = 8'h7A;
                default: ch = 8'($urandom);
            endcase
            cycle(($urandom_range(0, 7) == 0), ch);
        end
        idle(80);

        // Async reset in the middle of a HOLD
        cycle(1'b1, 8'h61);
        cycle(1'b1, 8'h62);
        cycle(1'b1, 8'h63);
        k = 0;
        while (o_dots == 6'b0 && k < 20) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        check("t6_in_hold", o_dots, 6'b000001);
        reset_n = 1'b0;
        #1;
        check("t6_rst_dots", o_dots, 0);
        check("t6_rst_cnt",  o_fifo_cnt, 0);
        check("t6_rst_busy", o_busy, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        clear_counts();
        idle(30);
        check("t6_no_done", done_cnt, 0);
        cycle(1'b1, 8'h63);
        idle(15);
        check("t6_after_rst_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
